// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand bypass and load-use bubble insertion.
// Latency: one cycle. ID inputs sampled at an edge appear on EX_* just after that edge.
// Backpressure: HOLD freezes the EX register. STALL asks upstream to re-present the same ID slot.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   ID_*                  decoded instruction fields and controls from the ID stage
//   RF_OUT1/2             register file read data for ID_RS1/ID_RS2
//   EXM_* / MWB_*         writeback candidates from EX/MEM and MEM/WB used for bypassing
//   FLUSH, HOLD           kill the ID instruction / freeze the EX register
//   STALL                 combinational request for upstream to hold
//   EX_*                  registered instruction presented to the EX stage
module id_ex_operand_stage #(
  parameter int NBITS = 32,
  parameter int AW    = 5,
  parameter int CTRLW = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ID_VALID,
  input  logic [AW-1:0]    ID_RS1,
  input  logic [AW-1:0]    ID_RS2,
  input  logic             ID_USE_RS1,
  input  logic             ID_USE_RS2,
  input  logic [AW-1:0]    ID_RD,
  input  logic             ID_REG_WRITE,
  input  logic             ID_MEM_READ,
  input  logic [NBITS-1:0] ID_IMM,
  input  logic [NBITS-1:0] ID_PC,
  input  logic [CTRLW-1:0] ID_CTRL,
  input  logic [NBITS-1:0] RF_OUT1,
  input  logic [NBITS-1:0] RF_OUT2,
  input  logic [AW-1:0]    EXM_RD,
  input  logic             EXM_WR,
  input  logic [NBITS-1:0] EXM_DATA,
  input  logic [AW-1:0]    MWB_RD,
  input  logic             MWB_WR,
  input  logic [NBITS-1:0] MWB_DATA,
  input  logic             FLUSH,
  input  logic             HOLD,
  output logic             STALL,
  output logic             EX_VALID,
  output logic [NBITS-1:0] EX_OP_A,
  output logic [NBITS-1:0] EX_OP_B,
  output logic [NBITS-1:0] EX_IMM,
  output logic [NBITS-1:0] EX_PC,
  output logic [AW-1:0]    EX_RD,
  output logic             EX_REG_WRITE,
  output logic             EX_MEM_READ,
  output logic [CTRLW-1:0] EX_CTRL
);

  logic             valid_q, valid_d;
  logic [NBITS-1:0] op_a_q, op_a_d;
  logic [NBITS-1:0] op_b_q, op_b_d;
  logic [NBITS-1:0] imm_q, imm_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_read_q, mem_read_d;
  logic [CTRLW-1:0] ctrl_q, ctrl_d;

  logic             load_use;
  logic             load_en;
  logic [NBITS-1:0] fwd_a, fwd_b;

  // EX/MEM beats MEM/WB (it is younger). MEM/WB also covers the case where the
  // RF is being written this same cycle and the read returned the old value.
  function automatic logic [NBITS-1:0] resolve(
    input logic [AW-1:0]    src,
    input logic [NBITS-1:0] rf_val,
    input logic [AW-1:0]    exm_rd,
    input logic             exm_wr,
    input logic [NBITS-1:0] exm_data,
    input logic [AW-1:0]    mwb_rd,
    input logic             mwb_wr,
    input logic [NBITS-1:0] mwb_data
  );
    logic [NBITS-1:0] r;
    if (src == '0)                         r = '0;
    else if (exm_wr && (exm_rd == src))    r = exm_data;
    else if (mwb_wr && (mwb_rd == src))    r = mwb_data;
    else                                   r = rf_val;
    return r;
  endfunction

  always_comb begin
    fwd_a = resolve(ID_RS1, RF_OUT1, EXM_RD, EXM_WR, EXM_DATA, MWB_RD, MWB_WR, MWB_DATA);
    fwd_b = resolve(ID_RS2, RF_OUT2, EXM_RD, EXM_WR, EXM_DATA, MWB_RD, MWB_WR, MWB_DATA);
  end

  // A load sitting in EX has no data until MEM/WB, so a dependent ID
  // instruction must wait one cycle behind a bubble.
  assign load_use = ID_VALID & valid_q & mem_read_q & (rd_q != '0) &
                    ((ID_USE_RS1 & (ID_RS1 == rd_q)) | (ID_USE_RS2 & (ID_RS2 == rd_q)));

  // A flushed instruction is dead anyway, so a hazard on it must not stall.
  assign STALL   = HOLD | (load_use & ~FLUSH);
  assign load_en = ID_VALID & ~FLUSH & ~load_use;

  always_comb begin
    valid_d     = valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    ctrl_d      = ctrl_q;
    if (!HOLD) begin
      if (load_en) begin
        valid_d     = 1'b1;
        op_a_d      = fwd_a;
        op_b_d      = fwd_b;
        imm_d       = ID_IMM;
        pc_d        = ID_PC;
        rd_d        = ID_RD;
        reg_write_d = ID_REG_WRITE;
        mem_read_d  = ID_MEM_READ;
        ctrl_d      = ID_CTRL;
      end else begin
        // Bubble: only the qualifying bits matter; data fields keep their old values.
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign EX_VALID     = valid_q;
  assign EX_OP_A      = op_a_q;
  assign EX_OP_B      = op_b_q;
  assign EX_IMM       = imm_q;
  assign EX_PC        = pc_q;
  assign EX_RD        = rd_q;
  assign EX_REG_WRITE = reg_write_q;
  assign EX_MEM_READ  = mem_read_q;
  assign EX_CTRL      = ctrl_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: directed vector table, reset-mid-stall sequence,
// then randomized traffic checked against a behavioural model of the EX register.
module tb_id_ex_operand_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ID_VALID, ID_USE_RS1, ID_USE_RS2, ID_REG_WRITE, ID_MEM_READ;
  logic [4:0]  ID_RS1, ID_RS2, ID_RD, EXM_RD, MWB_RD, EX_RD;
  logic [31:0] ID_IMM, ID_PC, RF_OUT1, RF_OUT2, EXM_DATA, MWB_DATA;
  logic [7:0]  ID_CTRL, EX_CTRL;
  logic        EXM_WR, MWB_WR, FLUSH, HOLD;
  logic        STALL, EX_VALID, EX_REG_WRITE, EX_MEM_READ;
  logic [31:0] EX_OP_A, EX_OP_B, EX_IMM, EX_PC;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  id_ex_operand_stage dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2), .ID_RD(ID_RD),
    .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ), .ID_IMM(ID_IMM),
    .ID_PC(ID_PC), .ID_CTRL(ID_CTRL), .RF_OUT1(RF_OUT1), .RF_OUT2(RF_OUT2),
    .EXM_RD(EXM_RD), .EXM_WR(EXM_WR), .EXM_DATA(EXM_DATA), .MWB_RD(MWB_RD),
    .MWB_WR(MWB_WR), .MWB_DATA(MWB_DATA), .FLUSH(FLUSH), .HOLD(HOLD), .STALL(STALL),
    .EX_VALID(EX_VALID), .EX_OP_A(EX_OP_A), .EX_OP_B(EX_OP_B), .EX_IMM(EX_IMM),
    .EX_PC(EX_PC), .EX_RD(EX_RD), .EX_REG_WRITE(EX_REG_WRITE),
    .EX_MEM_READ(EX_MEM_READ), .EX_CTRL(EX_CTRL)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        v;
    logic [4:0]  rs1;  logic u1;
    logic [4:0]  rs2;  logic u2;
    logic [4:0]  rd;   logic rw; logic mr;
    logic [31:0] rf1;  logic [31:0] rf2;
    logic [4:0]  xrd;  logic xwr; logic [31:0] xdat;
    logic [4:0]  mrd;  logic mwr; logic [31:0] mdat;
    logic        flush; logic hold;
    logic        e_stall; logic e_valid; logic e_rw; logic e_mr;
    logic [31:0] e_a;  logic [31:0] e_b;
  } vec_t;

  function automatic vec_t mk(int v, int rs1, int u1, int rs2, int u2, int rd, int rw, int mr,
                              int rf1, int rf2, int xrd, int xwr, int xdat,
                              int mrd, int mwr, int mdat, int fl, int hd,
                              int es, int ev, int erw, int emr, int ea, int eb);
    vec_t t;
    t.v = 1'(v); t.rs1 = 5'(rs1); t.u1 = 1'(u1); t.rs2 = 5'(rs2); t.u2 = 1'(u2);
    t.rd = 5'(rd); t.rw = 1'(rw); t.mr = 1'(mr);
    t.rf1 = 32'(rf1); t.rf2 = 32'(rf2);
    t.xrd = 5'(xrd); t.xwr = 1'(xwr); t.xdat = 32'(xdat);
    t.mrd = 5'(mrd); t.mwr = 1'(mwr); t.mdat = 32'(mdat);
    t.flush = 1'(fl); t.hold = 1'(hd);
    t.e_stall = 1'(es); t.e_valid = 1'(ev); t.e_rw = 1'(erw); t.e_mr = 1'(emr);
    t.e_a = 32'(ea); t.e_b = 32'(eb);
    return t;
  endfunction

  task automatic drive_vec(input vec_t t, input int idx);
    ID_VALID = t.v; ID_RS1 = t.rs1; ID_USE_RS1 = t.u1; ID_RS2 = t.rs2; ID_USE_RS2 = t.u2;
    ID_RD = t.rd; ID_REG_WRITE = t.rw; ID_MEM_READ = t.mr;
    ID_IMM = 32'(idx * 16 + 1); ID_PC = 32'h1000 + 32'(idx * 4); ID_CTRL = 8'(idx);
    RF_OUT1 = t.rf1; RF_OUT2 = t.rf2;
    EXM_RD = t.xrd; EXM_WR = t.xwr; EXM_DATA = t.xdat;
    MWB_RD = t.mrd; MWB_WR = t.mwr; MWB_DATA = t.mdat;
    FLUSH = t.flush; HOLD = t.hold;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v, rw, mr;
    logic [4:0]  rd;
    logic [31:0] a, b, imm, pc;
    logic [7:0]  ctrl;
  } ex_m_t;
  ex_m_t m;

  typedef struct { bit wr; logic [4:0] rd; logic [31:0] data; } src_t;

  // Walk bypass candidates youngest-first; fall back to the RF read.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
    src_t cand[2];
    if (r == 0) return 32'd0;
    cand[0] = '{EXM_WR, EXM_RD, EXM_DATA};
    cand[1] = '{MWB_WR, MWB_RD, MWB_DATA};
    foreach (cand[k]) if (cand[k].wr && cand[k].rd == r) return cand[k].data;
    return rf;
  endfunction

  function automatic bit model_lu();
    bit reads_it;
    reads_it = (ID_USE_RS1 && ID_RS1 == m.rd) || (ID_USE_RS2 && ID_RS2 == m.rd);
    return ID_VALID && m.v && m.mr && m.rd != 0 && reads_it;
  endfunction

  initial begin
    vec_t tbl[13];
    bit   lu;
    // EX/MEM beats MEM/WB
    tbl[0]  = mk(1,5,1,7,1, 9,1,0, 'h11,'h22, 5,1,'hAA, 5,1,'hBB, 0,0, 0,1,1,0, 'hAA,'h22);
    // x0 never forwarded
    tbl[1]  = mk(1,6,1,0,1, 9,1,0, 'h66,'h123, 0,1,'hFF, 0,1,'hEE, 0,0, 0,1,1,0, 'h66,'h0);
    // MEM/WB only on rs2, EX/MEM on rs1
    tbl[2]  = mk(1,3,1,7,1, 9,1,0, 'h1,'h2, 3,1,'h33, 7,1,'h77, 0,0, 0,1,1,0, 'h33,'h77);
    // lw x3, 0(x2)
    tbl[3]  = mk(1,2,1,0,0, 3,1,1, 'h100,'h0, 0,0,0, 0,0,0, 0,0, 0,1,1,1, 'h100,'h0);
    // add x4,x3,x1 behind the load: stall, bubble
    tbl[4]  = mk(1,3,1,1,1, 4,1,0, 'hDEAD,'h10, 0,0,0, 0,0,0, 0,0, 1,0,0,0, 0,0);
    // re-presented add takes the load data from MEM/WB
    tbl[5]  = mk(1,3,1,1,1, 4,1,0, 'hDEAD,'h10, 3,0,0, 3,1,'h5A5A, 0,0, 0,1,1,0, 'h5A5A,'h10);
    // lw x8
    tbl[6]  = mk(1,1,1,0,0, 8,1,1, 'h200,'h0, 0,0,0, 0,0,0, 0,0, 0,1,1,1, 'h200,'h0);
    // dependent on x8 but flushed: no stall, bubble
    tbl[7]  = mk(1,0,0,8,1, 9,1,0, 'h0,'h5, 0,0,0, 0,0,0, 1,0, 0,0,0,0, 0,0);
    // plain instruction then three HOLD cycles freezing it
    tbl[8]  = mk(1,1,1,2,1, 12,1,0, 'h42,'h43, 0,0,0, 0,0,0, 0,0, 0,1,1,0, 'h42,'h43);
    tbl[9]  = mk(1,1,1,2,1, 13,0,1, 'h99,'h98, 0,0,0, 0,0,0, 0,1, 1,1,1,0, 'h42,'h43);
    tbl[10] = mk(1,1,1,2,1, 13,0,1, 'h99,'h98, 0,0,0, 0,0,0, 0,1, 1,1,1,0, 'h42,'h43);
    tbl[11] = mk(0,1,1,2,1, 13,0,1, 'h99,'h98, 0,0,0, 0,0,0, 1,1, 1,1,1,0, 'h42,'h43);
    // empty decode slot: bubble
    tbl[12] = mk(0,1,1,2,1, 13,1,1, 'h99,'h98, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0);

    // ---- reset with garbage on every input ----
    RESET = 1'b1;
    ID_VALID = 1'b1; ID_RS1 = 5'd1; ID_RS2 = 5'd2; ID_USE_RS1 = 1'b1; ID_USE_RS2 = 1'b1;
    ID_RD = 5'd3; ID_REG_WRITE = 1'b1; ID_MEM_READ = 1'b1; ID_IMM = 32'hCAFE0001;
    ID_PC = 32'hBEEF0000; ID_CTRL = 8'hA5; RF_OUT1 = 32'h12345678; RF_OUT2 = 32'h9ABCDEF0;
    EXM_RD = 5'd1; EXM_WR = 1'b1; EXM_DATA = 32'hFFFF0000; MWB_RD = 5'd2; MWB_WR = 1'b1;
    MWB_DATA = 32'h0000FFFF; FLUSH = 1'b0; HOLD = 1'b0;
    @(posedge CLK); #1;
    chk("rst_valid", 32'(EX_VALID), 0);
    chk("rst_op_a", EX_OP_A, 0);
    chk("rst_op_b", EX_OP_B, 0);
    chk("rst_imm", EX_IMM, 0);
    chk("rst_pc", EX_PC, 0);
    chk("rst_rd", 32'(EX_RD), 0);
    chk("rst_rw", 32'(EX_REG_WRITE), 0);
    chk("rst_mr", 32'(EX_MEM_READ), 0);
    chk("rst_ctrl", 32'(EX_CTRL), 0);
    RESET = 1'b0;

    // ---- directed table ----
    for (int i = 0; i < 13; i++) begin
      drive_vec(tbl[i], i);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(STALL), 32'(tbl[i].e_stall));
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_valid", i), 32'(EX_VALID), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_rw", i), 32'(EX_REG_WRITE), 32'(tbl[i].e_rw));
      chk($sformatf("vec%0d_mr", i), 32'(EX_MEM_READ), 32'(tbl[i].e_mr));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_op_a", i), EX_OP_A, tbl[i].e_a);
        chk($sformatf("vec%0d_op_b", i), EX_OP_B, tbl[i].e_b);
      end
    end
    chk("held_pc", EX_PC, 32'h1000 + 32'd32);

    // ---- reset in the middle of a load-use stall ----
    drive_vec(mk(1,1,1,0,0, 6,1,1, 'h1,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0), 20);
    @(posedge CLK); #1;
    drive_vec(mk(1,6,1,0,0, 7,1,0, 'h1,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0), 21);
    #1;
    chk("mid_stall_pre", 32'(STALL), 1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("mid_stall_after_rst", 32'(STALL), 0);
    chk("mid_stall_valid", 32'(EX_VALID), 0);
    chk("mid_stall_mr", 32'(EX_MEM_READ), 0);

    // ---- randomized traffic against the model ----
    do_reset();
    m = '{default: '0};
    for (int c = 0; c < 800; c++) begin
      RESET        = ($urandom_range(0, 60) == 0);
      ID_VALID     = ($urandom_range(0, 5) != 0);
      ID_RS1       = 5'($urandom_range(0, 3));
      ID_RS2       = 5'($urandom_range(0, 3));
      ID_USE_RS1   = 1'($urandom);
      ID_USE_RS2   = 1'($urandom);
      ID_RD        = 5'($urandom_range(0, 3));
      ID_REG_WRITE = 1'($urandom);
      ID_MEM_READ  = ($urandom_range(0, 2) == 0);
      ID_IMM       = $urandom;
      ID_PC        = $urandom;
      ID_CTRL      = 8'($urandom);
      RF_OUT1      = $urandom;
      RF_OUT2      = $urandom;
      EXM_RD       = 5'($urandom_range(0, 3));
      EXM_WR       = 1'($urandom);
      EXM_DATA     = $urandom;
      MWB_RD       = 5'($urandom_range(0, 3));
      MWB_WR       = 1'($urandom);
      MWB_DATA     = $urandom;
      FLUSH        = ($urandom_range(0, 7) == 0);
      HOLD         = ($urandom_range(0, 7) == 0);
      #1;
      lu = model_lu();
      chk("rnd_stall", 32'(STALL), 32'(HOLD || (lu && !FLUSH)));
      if (RESET) begin
        m = '{default: '0};
      end else if (HOLD) begin
        // frozen
      end else if (FLUSH || lu || !ID_VALID) begin
        m.v = 0; m.rw = 0; m.mr = 0;
      end else begin
        m.v = 1; m.rw = ID_REG_WRITE; m.mr = ID_MEM_READ; m.rd = ID_RD;
        m.a = operand(ID_RS1, RF_OUT1); m.b = operand(ID_RS2, RF_OUT2);
        m.imm = ID_IMM; m.pc = ID_PC; m.ctrl = ID_CTRL;
      end
      @(posedge CLK); #1;
      chk("rnd_valid", 32'(EX_VALID), 32'(m.v));
      chk("rnd_rw", 32'(EX_REG_WRITE), 32'(m.rw));
      chk("rnd_mr", 32'(EX_MEM_READ), 32'(m.mr));
      if (m.v) begin
        chk("rnd_op_a", EX_OP_A, m.a);
        chk("rnd_op_b", EX_OP_B, m.b);
        chk("rnd_imm", EX_IMM, m.imm);
        chk("rnd_pc", EX_PC, m.pc);
        chk("rnd_rd", 32'(EX_RD), 32'(m.rd));
        chk("rnd_ctrl", 32'(EX_CTRL), 32'(m.ctrl));
      end
    end
    RESET = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
